// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the byte-wide RAM controller.
// Imported by mem_ctrl; nothing in here holds state.
package mem_ctrl_pkg;

    localparam int RAM_AW_DEFAULT = 17;

    typedef logic [RAM_AW_DEFAULT-1:0] ram_addr_t;
    typedef logic [1:0]                mem_len_t;

    // Length codes are byte count minus one.
    localparam mem_len_t MemLenByte = 2'd0;
    localparam mem_len_t MemLenHalf = 2'd1;
    localparam mem_len_t MemLenWord = 2'd3;

    typedef enum logic [1:0] {
        CtrlIdle  = 2'd0,
        CtrlRead  = 2'd1,
        CtrlWrite = 2'd2
    } ctrl_state_e;

    typedef enum logic {
        OwnerI = 1'b0,
        OwnerD = 1'b1
    } owner_e;

    function automatic logic [7:0] byte_sel(input logic [31:0] word, input logic [1:0] idx);
        return word[8*idx +: 8];
    endfunction

endpackage

// File: rtl/mem_ctrl.sv
// Arbitrates the icache read port and the MEM-stage data port onto a byte-wide
// synchronous RAM, assembling/splitting little-endian multi-byte transfers.
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int RAM_AW = RAM_AW_DEFAULT
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              i_read,
    input  logic [31:0]       i_addr,
    output logic              i_busy,
    output logic              i_ready,
    output logic [31:0]       i_data,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [31:0]       d_addr,
    input  logic [1:0]        d_len,
    input  logic [31:0]       d_wdata,
    output logic              d_busy,
    output logic              d_ready,
    output logic [31:0]       d_rdata,
    input  logic [7:0]        mem_din,
    output logic [7:0]        mem_dout,
    output logic [RAM_AW-1:0] mem_a,
    output logic              mem_wr
);

    ctrl_state_e       state_q, state_d;
    logic [2:0]        cnt_q, cnt_d;
    mem_len_t          len_q, len_d;
    owner_e            owner_q, owner_d;
    logic [RAM_AW-1:0] base_q, base_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       buf_q, buf_d;
    logic              i_ready_q, i_ready_d;
    logic [31:0]       i_data_q, i_data_d;
    logic              d_ready_q, d_ready_d;
    logic [31:0]       d_rdata_q, d_rdata_d;
    logic [RAM_AW-1:0] mem_a_q, mem_a_d;
    logic              mem_wr_q, mem_wr_d;
    logic [7:0]        mem_dout_q, mem_dout_d;
    logic [1:0]        cap_idx;

    // Address bits above the RAM are deliberately ignored.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{i_addr[31:RAM_AW], d_addr[31:RAM_AW]};

    always_comb begin
        // NOTE: every _d starts from its _q (pulses from 0) so no branch can infer a latch.
        state_d    = state_q;
        cnt_d      = cnt_q;
        len_d      = len_q;
        owner_d    = owner_q;
        base_d     = base_q;
        wdata_d    = wdata_q;
        buf_d      = buf_q;
        i_ready_d  = 1'b0;
        i_data_d   = i_data_q;
        d_ready_d  = 1'b0;
        d_rdata_d  = d_rdata_q;
        mem_a_d    = mem_a_q;
        mem_wr_d   = 1'b0;
        mem_dout_d = mem_dout_q;
        cap_idx    = 2'(cnt_q - 3'd1);

        unique case (state_q)
            CtrlIdle: begin
                // A port whose ready is high this cycle is masked to avoid re-issuing.
                if (d_write && !d_ready_q) begin
                    state_d    = CtrlWrite;
                    owner_d    = OwnerD;
                    base_d     = d_addr[RAM_AW-1:0];
                    len_d      = d_len;
                    wdata_d    = d_wdata;
                    cnt_d      = 3'd0;
                    mem_wr_d   = 1'b1;
                    mem_a_d    = d_addr[RAM_AW-1:0];
                    mem_dout_d = d_wdata[7:0];
                end else if (d_read && !d_ready_q) begin
                    state_d = CtrlRead;
                    owner_d = OwnerD;
                    base_d  = d_addr[RAM_AW-1:0];
                    len_d   = d_len;
                    cnt_d   = 3'd0;
                    buf_d   = '0;
                    mem_a_d = d_addr[RAM_AW-1:0];
                end else if (i_read && !i_ready_q) begin
                    state_d = CtrlRead;
                    owner_d = OwnerI;
                    base_d  = i_addr[RAM_AW-1:0];
                    len_d   = MemLenWord;
                    cnt_d   = 3'd0;
                    buf_d   = '0;
                    mem_a_d = i_addr[RAM_AW-1:0];
                end
            end

            CtrlRead: begin
                // RAM returns a byte one cycle after its address, so capture lags issue by one.
                cnt_d = cnt_q + 3'd1;
                if (cnt_q != 3'd0) begin
                    buf_d[8*cap_idx +: 8] = mem_din;
                end
                if (cnt_q < {1'b0, len_q}) begin
                    mem_a_d = base_q + RAM_AW'(cnt_q + 3'd1);
                end
                if (cnt_q == {1'b0, len_q} + 3'd1) begin
                    state_d = CtrlIdle;
                    cnt_d   = 3'd0;
                    if (owner_q == OwnerI) begin
                        i_ready_d = 1'b1;
                        i_data_d  = buf_d;
                    end else begin
                        d_ready_d = 1'b1;
                        d_rdata_d = buf_d;
                    end
                end
            end

            CtrlWrite: begin
                if (cnt_q == {1'b0, len_q}) begin
                    state_d   = CtrlIdle;
                    cnt_d     = 3'd0;
                    d_ready_d = 1'b1;
                end else begin
                    cnt_d      = cnt_q + 3'd1;
                    mem_wr_d   = 1'b1;
                    mem_a_d    = base_q + RAM_AW'(cnt_q + 3'd1);
                    mem_dout_d = byte_sel(wdata_q, 2'(cnt_q + 3'd1));
                end
            end

            default: begin
                state_d = CtrlIdle;
                cnt_d   = 3'd0;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= CtrlIdle;
            cnt_q      <= 3'd0;
            len_q      <= MemLenByte;
            owner_q    <= OwnerI;
            base_q     <= '0;
            wdata_q    <= '0;
            buf_q      <= '0;
            i_ready_q  <= 1'b0;
            i_data_q   <= '0;
            d_ready_q  <= 1'b0;
            d_rdata_q  <= '0;
            mem_a_q    <= '0;
            mem_wr_q   <= 1'b0;
            mem_dout_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            len_q      <= len_d;
            owner_q    <= owner_d;
            base_q     <= base_d;
            wdata_q    <= wdata_d;
            buf_q      <= buf_d;
            i_ready_q  <= i_ready_d;
            i_data_q   <= i_data_d;
            d_ready_q  <= d_ready_d;
            d_rdata_q  <= d_rdata_d;
            mem_a_q    <= mem_a_d;
            mem_wr_q   <= mem_wr_d;
            mem_dout_q <= mem_dout_d;
        end
    end

    assign i_busy   = (state_q != CtrlIdle);
    assign d_busy   = (state_q != CtrlIdle);
    assign i_ready  = i_ready_q;
    assign i_data   = i_data_q;
    assign d_ready  = d_ready_q;
    assign d_rdata  = d_rdata_q;
    assign mem_a    = mem_a_q;
    assign mem_wr   = mem_wr_q;
    assign mem_dout = mem_dout_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Self-checking bench for mem_ctrl: directed scenarios plus randomized transactions
// checked cycle by cycle against a byte-array reference memory.
module tb_mem_ctrl;

    localparam int AW       = 17;
    localparam int RAM_SIZE = 1 << AW;

    logic          clock = 1'b0;
    logic          reset;
    logic          i_read, i_busy, i_ready;
    logic [31:0]   i_addr, i_data;
    logic          d_read, d_write, d_busy, d_ready;
    logic [31:0]   d_addr, d_wdata, d_rdata;
    logic [1:0]    d_len;
    logic [7:0]    mem_din, mem_dout;
    logic [AW-1:0] mem_a;
    logic          mem_wr;

    logic [7:0] ram     [RAM_SIZE];
    logic [7:0] ref_mem [RAM_SIZE];
    bit         preloaded = 1'b0;

    int checks = 0;
    int passes = 0;
    int fails  = 0;

    always #5 clock = ~clock;

    mem_ctrl #(.RAM_AW(AW)) dut (
        .clock    (clock),
        .reset    (reset),
        .i_read   (i_read),
        .i_addr   (i_addr),
        .i_busy   (i_busy),
        .i_ready  (i_ready),
        .i_data   (i_data),
        .d_read   (d_read),
        .d_write  (d_write),
        .d_addr   (d_addr),
        .d_len    (d_len),
        .d_wdata  (d_wdata),
        .d_busy   (d_busy),
        .d_ready  (d_ready),
        .d_rdata  (d_rdata),
        .mem_din  (mem_din),
        .mem_dout (mem_dout),
        .mem_a    (mem_a),
        .mem_wr   (mem_wr)
    );

    // Synchronous byte RAM; contents are copied from the reference image on the first edge.
    always @(posedge clock) begin
        if (!preloaded) begin
            for (int i = 0; i < RAM_SIZE; i++) ram[i] <= ref_mem[i];
            preloaded <= 1'b1;
        end else begin
            if (mem_wr) ram[mem_a] <= mem_dout;
            mem_din <= ram[mem_a];
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // kind: 0 = icache read, 1 = data load, 2 = data store. Called in cycle 0 with the
    // controller idle; returns in the ready cycle (tail=0) or one cycle after it (tail=1).
    task automatic run_txn(input int kind, input logic [31:0] addr, input logic [1:0] len,
                           input logic [31:0] wdata, input bit hold_i, input bit tail,
                           input string tag);
        int            n;
        logic [AW-1:0] base;
        logic [AW-1:0] a;
        logic [31:0]   expv;
        n    = (kind == 0) ? 4 : int'(len) + 1;
        base = addr[AW-1:0];
        expv = 32'h0;
        for (int k = 0; k < n; k++) begin
            a = base + AW'(k);
            expv[8*k +: 8] = (kind == 2) ? wdata[8*k +: 8] : ref_mem[a];
        end
        if (kind == 0) begin
            i_read = 1'b1;
            i_addr = addr;
        end else if (kind == 1) begin
            d_read  = 1'b1;
            d_write = 1'b0;
            d_addr  = addr;
            d_len   = len;
        end else begin
            d_write = 1'b1;
            d_read  = 1'($urandom_range(0, 1));
            d_addr  = addr;
            d_len   = len;
            d_wdata = wdata;
        end
        step();
        if (!hold_i) i_read = 1'b0;
        d_read  = 1'b0;
        d_write = 1'b0;
        i_addr  = $urandom;
        d_addr  = $urandom;
        d_len   = 2'($urandom);
        d_wdata = $urandom;

        if (kind == 2) begin
            for (int c = 1; c <= n; c++) begin
                a = base + AW'(c - 1);
                check($sformatf("%s c%0d d_busy", tag, c), 32'(d_busy), 32'd1);
                check($sformatf("%s c%0d mem_wr", tag, c), 32'(mem_wr), 32'd1);
                check($sformatf("%s c%0d mem_a", tag, c), 32'(mem_a), 32'(a));
                check($sformatf("%s c%0d mem_dout", tag, c), 32'(mem_dout), 32'(wdata[8*(c-1) +: 8]));
                check($sformatf("%s c%0d d_ready", tag, c), 32'(d_ready), 32'd0);
                step();
            end
            check($sformatf("%s rdy d_ready", tag), 32'(d_ready), 32'd1);
            check($sformatf("%s rdy mem_wr", tag), 32'(mem_wr), 32'd0);
            check($sformatf("%s rdy d_busy", tag), 32'(d_busy), 32'd0);
            check($sformatf("%s rdy i_ready", tag), 32'(i_ready), 32'd0);
            for (int k = 0; k < n; k++) begin
                a = base + AW'(k);
                ref_mem[a] = wdata[8*k +: 8];
                check($sformatf("%s ram[%h]", tag, a), 32'(ram[a]), 32'(ref_mem[a]));
            end
        end else begin
            for (int c = 1; c <= n + 1; c++) begin
                a = base + AW'(c - 1);
                check($sformatf("%s c%0d i_busy", tag, c), 32'(i_busy), 32'd1);
                check($sformatf("%s c%0d i_ready", tag, c), 32'(i_ready), 32'd0);
                check($sformatf("%s c%0d d_ready", tag, c), 32'(d_ready), 32'd0);
                if (c <= n) begin
                    check($sformatf("%s c%0d mem_a", tag, c), 32'(mem_a), 32'(a));
                    check($sformatf("%s c%0d mem_wr", tag, c), 32'(mem_wr), 32'd0);
                end
                step();
            end
            check($sformatf("%s rdy busy", tag), 32'(i_busy), 32'd0);
            if (kind == 0) begin
                check($sformatf("%s rdy i_ready", tag), 32'(i_ready), 32'd1);
                check($sformatf("%s rdy d_ready", tag), 32'(d_ready), 32'd0);
                check($sformatf("%s rdy i_data", tag), i_data, expv);
            end else begin
                check($sformatf("%s rdy d_ready", tag), 32'(d_ready), 32'd1);
                check($sformatf("%s rdy i_ready", tag), 32'(i_ready), 32'd0);
                check($sformatf("%s rdy d_rdata", tag), d_rdata, expv);
            end
        end

        if (tail) begin
            step();
            check($sformatf("%s tail i_busy", tag), 32'(i_busy), 32'd0);
            check($sformatf("%s tail i_ready", tag), 32'(i_ready), 32'd0);
            check($sformatf("%s tail d_ready", tag), 32'(d_ready), 32'd0);
            if (kind == 0) check($sformatf("%s tail i_data", tag), i_data, expv);
            if (kind == 1) check($sformatf("%s tail d_rdata", tag), d_rdata, expv);
            i_read = 1'b0;
        end
    endtask

    initial begin
        int          kind;
        logic [31:0] addr;

        reset   = 1'b0;
        i_read  = 1'b0;
        i_addr  = 32'h0;
        d_read  = 1'b0;
        d_write = 1'b0;
        d_addr  = 32'h0;
        d_len   = 2'd0;
        d_wdata = 32'h0;
        for (int i = 0; i < RAM_SIZE; i++) ref_mem[i] = 8'($urandom);
        ref_mem[32'h10] = 8'h13;
        ref_mem[32'h11] = 8'h37;
        ref_mem[32'h12] = 8'hBE;
        ref_mem[32'h13] = 8'hEF;

        // Reset state
        step();
        step();
        check("rst i_busy", 32'(i_busy), 32'd0);
        check("rst d_busy", 32'(d_busy), 32'd0);
        check("rst i_ready", 32'(i_ready), 32'd0);
        check("rst d_ready", 32'(d_ready), 32'd0);
        check("rst i_data", i_data, 32'd0);
        check("rst d_rdata", d_rdata, 32'd0);
        check("rst mem_a", 32'(mem_a), 32'd0);
        check("rst mem_wr", 32'(mem_wr), 32'd0);
        check("rst mem_dout", 32'(mem_dout), 32'd0);
        reset = 1'b1;
        step();

        // Word fetch from preloaded bytes
        run_txn(0, 32'h10, 2'd3, 32'h0, 1'b0, 1'b1, "t1");
        check("t1 word", i_data, 32'hEFBE3713);

        // Simultaneous store and fetch: store wins, fetch granted in the store's ready cycle
        i_read = 1'b1;
        i_addr = 32'h0;
        run_txn(2, 32'h100, 2'd3, 32'hAABBCCDD, 1'b1, 1'b0, "t2w");
        run_txn(0, 32'h0, 2'd3, 32'h0, 1'b0, 1'b1, "t2i");
        check("t2 ram100", 32'(ram[17'h100]), 32'hDD);
        check("t2 ram103", 32'(ram[17'h103]), 32'hAA);

        // Short loads, zero-extended
        run_txn(1, 32'h101, 2'd0, 32'h0, 1'b0, 1'b1, "t3b");
        check("t3 byte", d_rdata, 32'h000000CC);
        run_txn(1, 32'h102, 2'd1, 32'h0, 1'b0, 1'b1, "t3h");
        check("t3 half", d_rdata, 32'h0000AABB);

        // Address wrap at the top of RAM, upper address bits ignored
        run_txn(0, 32'h0003_FFFE, 2'd3, 32'h0, 1'b0, 1'b1, "t4wrap");

        // Reset during a store after two bytes
        d_write = 1'b1;
        d_addr  = 32'h200;
        d_len   = 2'd3;
        d_wdata = 32'h11223344;
        step();
        d_write = 1'b0;
        check("t5 c1 mem_wr", 32'(mem_wr), 32'd1);
        step();
        check("t5 c2 mem_wr", 32'(mem_wr), 32'd1);
        step();
        check("t5 c3 mem_wr", 32'(mem_wr), 32'd1);
        reset = 1'b0;
        #1;
        check("t5 async mem_wr", 32'(mem_wr), 32'd0);
        check("t5 async mem_a", 32'(mem_a), 32'd0);
        check("t5 async d_busy", 32'(d_busy), 32'd0);
        ref_mem[17'h200] = 8'h44;
        ref_mem[17'h201] = 8'h33;
        step();
        check("t5 rst d_ready", 32'(d_ready), 32'd0);
        step();
        reset = 1'b1;
        step();
        check("t5 post d_ready", 32'(d_ready), 32'd0);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("t5 ram[%0h]", 32'h200 + k), 32'(ram[17'h200 + 17'(k)]),
                  32'(ref_mem[17'h200 + 17'(k)]));
        end
        run_txn(0, 32'h200, 2'd3, 32'h0, 1'b0, 1'b1, "t5i");

        // Fetch request held through its own ready cycle
        run_txn(0, 32'h40, 2'd3, 32'h0, 1'b1, 1'b1, "t6hold");

        // Randomized mix
        for (int t = 0; t < 40; t++) begin
            kind = int'($urandom_range(0, 2));
            addr = $urandom;
            if ($urandom_range(0, 3) == 0) addr = 32'h1FFFC + $urandom_range(0, 3);
            run_txn(kind, addr, 2'($urandom), $urandom, 1'b0, 1'b1, $sformatf("rnd%0d", t));
            repeat ($urandom_range(0, 2)) step();
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
